// File: rtl/lisp_pkg.sv
// Shared definitions for the cons unit and the heap memory it talks to.
package lisp_pkg;

    localparam int ADDR_W   = 12;
    localparam int DATA_W   = 16;
    localparam int MEM_SIZE = 256;
    localparam int NIL_ADDR = 0;

    typedef enum logic [1:0] {
        CONS = 2'd0,
        CAR  = 2'd1,
        CDR  = 2'd2,
        RSVD = 2'd3
    } op_e;

endpackage

// File: rtl/cons_unit_if.sv
// Command/response handshake plus heap read/append port of the cons unit.
interface cons_unit_if #(
    parameter int ADDR_W = lisp_pkg::ADDR_W,
    parameter int DATA_W = lisp_pkg::DATA_W
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [1:0]        cmd_op;
    logic [DATA_W-1:0] cmd_car;
    logic [DATA_W-1:0] cmd_cdr;
    logic [ADDR_W-1:0] cmd_ptr;

    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_data;
    logic              rsp_err;

    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_data_ready;
    logic [DATA_W-1:0] mem_data;
    logic              mem_we;
    logic [DATA_W-1:0] mem_wdata;
    logic [ADDR_W-1:0] mem_waddr;

    // client and heap side
    modport master (
        output cmd_valid, cmd_op, cmd_car, cmd_cdr, cmd_ptr, rsp_ready,
        output mem_data_ready, mem_data, mem_waddr,
        input  cmd_ready, rsp_valid, rsp_data, rsp_err,
        input  mem_req, mem_addr, mem_we, mem_wdata
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_car, cmd_cdr, cmd_ptr, rsp_ready,
        input  mem_data_ready, mem_data, mem_waddr,
        output cmd_ready, rsp_valid, rsp_data, rsp_err,
        output mem_req, mem_addr, mem_we, mem_wdata
    );

endinterface

// File: rtl/cons_unit.sv
// Lisp cons-cell unit: CONS appends CDR then CAR to the heap, CAR/CDR read a cell.
// One command in flight; the heap allocates addresses and reports them back.
module cons_unit #(
    parameter int ADDR_W   = lisp_pkg::ADDR_W,
    parameter int DATA_W   = lisp_pkg::DATA_W,
    parameter int MEM_SIZE = lisp_pkg::MEM_SIZE,
    parameter int NIL_ADDR = lisp_pkg::NIL_ADDR
) (
    input logic        clk,
    input logic        rst_n,
    cons_unit_if.slave bus
);
    import lisp_pkg::*;

    typedef enum logic [2:0] {
        IDLE, WR_CDR, WR_CAR, RD_REQ, RD_WAIT, RESP
    } state_e;

    // A cell occupies p and p+1, so the last usable pointer is MEM_SIZE-2.
    localparam logic [ADDR_W-1:0] LAST_A = ADDR_W'(MEM_SIZE - 1);
    localparam logic [ADDR_W-1:0] NIL_A  = ADDR_W'(NIL_ADDR);

    state_e            state, state_nx;
    op_e               op_q;
    logic [DATA_W-1:0] car_q, cdr_q;
    logic [ADDR_W-1:0] ptr_q;
    logic [DATA_W-1:0] data_q;
    logic              err_q;

    op_e  op_c;
    logic is_read, ptr_nil, ptr_bad;

    always_comb begin
        op_c    = op_e'(bus.cmd_op);
        is_read = (op_c == CAR) || (op_c == CDR);
        ptr_nil = (bus.cmd_ptr == NIL_A);
        ptr_bad = (bus.cmd_ptr >= LAST_A);
    end

    always_comb begin
        state_nx      = state;
        bus.cmd_ready = 1'b0;
        bus.rsp_valid = 1'b0;
        bus.mem_req   = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_we    = 1'b0;
        bus.mem_wdata = '0;
        unique case (state)
            IDLE: begin
                bus.cmd_ready = 1'b1;
                if (bus.cmd_valid) begin
                    if (op_c == CONS)
                        state_nx = WR_CDR;
                    else if (is_read && !ptr_nil && !ptr_bad)
                        state_nx = RD_REQ;
                    else
                        state_nx = RESP;
                end
            end
            WR_CDR: begin
                bus.mem_we    = 1'b1;
                bus.mem_wdata = cdr_q;
                state_nx      = WR_CAR;
            end
            WR_CAR: begin
                bus.mem_we    = 1'b1;
                bus.mem_wdata = car_q;
                state_nx      = RESP;
            end
            RD_REQ: begin
                bus.mem_req  = 1'b1;
                bus.mem_addr = (op_q == CAR) ? ptr_q + ADDR_W'(1) : ptr_q;
                state_nx     = RD_WAIT;
            end
            RD_WAIT: begin
                if (bus.mem_data_ready)
                    state_nx = RESP;
            end
            RESP: begin
                bus.rsp_valid = 1'b1;
                if (bus.rsp_ready)
                    state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            op_q   <= CONS;
            car_q  <= '0;
            cdr_q  <= '0;
            ptr_q  <= '0;
            data_q <= '0;
            err_q  <= 1'b0;
        end else begin
            state <= state_nx;
            if (state == IDLE && bus.cmd_valid) begin
                op_q   <= op_c;
                car_q  <= bus.cmd_car;
                cdr_q  <= bus.cmd_cdr;
                ptr_q  <= bus.cmd_ptr;
                data_q <= '0;
                err_q  <= (op_c == RSVD) || (is_read && !ptr_nil && ptr_bad);
            end
            // mem_waddr now reports the CDR write, i.e. the new cell pointer.
            if (state == WR_CAR) begin
                if (bus.mem_waddr >= LAST_A) begin
                    err_q  <= 1'b1;
                    data_q <= '0;
                end else begin
                    data_q <= DATA_W'(bus.mem_waddr);
                end
            end
            if (state == RD_WAIT && bus.mem_data_ready)
                data_q <= bus.mem_data;
        end
    end

    assign bus.rsp_data = data_q;
    assign bus.rsp_err  = err_q;

endmodule

// File: tb/tb_cons_unit.sv
// Randomised scoreboard bench for cons_unit with an append-only heap model.
module tb_cons_unit;
    import lisp_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int   cyc   = 0;
    int   n_chk = 0;
    int   n_fail = 0;

    cons_unit_if bus ();
    cons_unit dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [15:0] data;
        logic        err;
        int          lat;
        int          acc;
    } exp_t;

    exp_t        sb[$];
    logic [15:0] exp_wr[$];
    logic [11:0] exp_rd[$];
    logic [11:0] cons_ptrs[$];

    logic [15:0] mdl_mem [0:4095];
    int          mdl_next;
    logic [15:0] heap [0:4095];
    int          hp_next;
    int          rdy_mode = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        n_chk++;
        n_fail++;
        $display("FAIL %s: wait bound expired (cycle %0d)", name, cyc);
    endtask

    // heap: append writes at hp_next, answer reads one cycle after mem_req
    logic        we_s = 1'b0, rq_s = 1'b0;
    logic [15:0] wd_s;
    logic [11:0] ra_s;
    always @(negedge clk) begin
        we_s = 1'b0;
        rq_s = 1'b0;
        if (rst_n) begin
            if (bus.mem_we) begin
                chk("req_we_exclusive", bus.mem_req, 0);
                we_s = 1'b1;
                wd_s = bus.mem_wdata;
                chk("write_expected", exp_wr.size() != 0, 1);
                if (exp_wr.size() != 0) chk("mem_wdata", wd_s, exp_wr.pop_front());
            end
            if (bus.mem_req) begin
                rq_s = 1'b1;
                ra_s = bus.mem_addr;
                chk("read_expected", exp_rd.size() != 0, 1);
                if (exp_rd.size() != 0) chk("mem_addr", ra_s, exp_rd.pop_front());
            end
        end
    end
    always @(posedge clk) begin
        if (we_s) begin
            heap[hp_next]  <= wd_s;
            bus.mem_waddr  <= hp_next[11:0];
            hp_next        <= hp_next + 1;
        end
        bus.mem_data_ready <= rq_s;
        bus.mem_data       <= rq_s ? heap[ra_s] : 16'hdead;
    end

    // response monitor
    logic        hold_v = 1'b0, was_hs = 1'b0, seen = 1'b0;
    logic [15:0] hold_d;
    logic        hold_e;
    exp_t        e_m;
    always @(negedge clk) begin
        if (!rst_n) begin
            hold_v = 1'b0; was_hs = 1'b0; seen = 1'b0;
        end else begin
            if (was_hs) begin
                chk("idle_after_handshake", bus.cmd_ready, 1);
                chk("valid_drop_after_handshake", bus.rsp_valid, 0);
            end
            was_hs = 1'b0;
            if (bus.rsp_valid) begin
                chk("cmd_ready_low_in_resp", bus.cmd_ready, 0);
                if (hold_v) begin
                    chk("rsp_data_stable", bus.rsp_data, hold_d);
                    chk("rsp_err_stable", bus.rsp_err, hold_e);
                end
                if (!seen) begin
                    seen = 1'b1;
                    chk("rsp_expected", sb.size() != 0, 1);
                    if (sb.size() != 0) chk("latency", cyc - sb[0].acc, sb[0].lat);
                end
                if (bus.rsp_ready) begin
                    if (sb.size() != 0) begin
                        e_m = sb.pop_front();
                        chk("rsp_data", bus.rsp_data, e_m.data);
                        chk("rsp_err", bus.rsp_err, e_m.err);
                    end
                    hold_v = 1'b0; seen = 1'b0; was_hs = 1'b1;
                end else begin
                    hold_v = 1'b1; hold_d = bus.rsp_data; hold_e = bus.rsp_err;
                end
            end else begin
                hold_v = 1'b0;
            end
        end
    end

    initial begin
        bus.rsp_ready = 1'b0;
        forever begin
            @(posedge clk); #1;
            case (rdy_mode)
                0:       bus.rsp_ready = ($urandom_range(0, 3) != 0);
                1:       bus.rsp_ready = 1'b0;
                default: bus.rsp_ready = 1'b1;
            endcase
        end
    end

    // Drive one command; the expectation is computed from the cell rules at acceptance.
    task automatic issue(input logic [1:0] op, input logic [15:0] car, input logic [15:0] cdr,
                         input logic [11:0] ptr);
        exp_t e;
        int   t, p, a;
        @(posedge clk); #1;
        bus.cmd_valid = 1'b1;
        bus.cmd_op = op; bus.cmd_car = car; bus.cmd_cdr = cdr; bus.cmd_ptr = ptr;
        t = 0;
        forever begin
            @(negedge clk);
            if (bus.cmd_ready) break;
            if (++t > 200) begin
                fail_now("cmd_accept");
                bus.cmd_valid = 1'b0;
                return;
            end
        end
        e.acc = cyc;
        e.data = 16'h0; e.err = 1'b0; e.lat = 1;
        if (op == 2'd0) begin
            p = mdl_next;
            mdl_next += 2;
            mdl_mem[p] = cdr; mdl_mem[p+1] = car;
            exp_wr.push_back(cdr); exp_wr.push_back(car);
            cons_ptrs.push_back(p[11:0]);
            e.lat = 3;
            if (p >= MEM_SIZE - 1) e.err = 1'b1;
            else e.data = p[15:0];
        end else if (op == 2'd3) begin
            e.err = 1'b1;
        end else if (ptr == 12'd0) begin
            e.err = 1'b0;
        end else if (int'(ptr) >= MEM_SIZE - 1) begin
            e.err = 1'b1;
        end else begin
            a = int'(ptr) + ((op == 2'd1) ? 1 : 0);
            exp_rd.push_back(a[11:0]);
            e.data = mdl_mem[a];
            e.lat = 3;
        end
        sb.push_back(e);
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
        bus.cmd_op  = 2'($urandom);
        bus.cmd_car = 16'($urandom);
        bus.cmd_cdr = 16'($urandom);
        bus.cmd_ptr = 12'($urandom);
    endtask

    task automatic drain(input string name);
        int t = 0;
        while (sb.size() != 0 && t < 500) begin
            @(negedge clk); t++;
        end
        if (sb.size() != 0) fail_now(name);
    endtask

    logic [11:0] rp;
    int          r, t0, keep;

    initial begin
        for (int i = 0; i < 4096; i++) begin
            heap[i] = 16'h0; mdl_mem[i] = 16'h0;
        end
        heap[3] = 16'h0001; heap[4] = 16'h0002;
        mdl_mem[3] = 16'h0001; mdl_mem[4] = 16'h0002;
        hp_next = 5; mdl_next = 5;
        bus.mem_waddr = '0; bus.mem_data_ready = 1'b0; bus.mem_data = '0;
        bus.cmd_valid = 1'b0; bus.cmd_op = '0; bus.cmd_car = '0; bus.cmd_cdr = '0; bus.cmd_ptr = '0;

        #2 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_cmd_ready", bus.cmd_ready, 1);
        chk("rst_rsp_valid", bus.rsp_valid, 0);
        chk("rst_rsp_data", bus.rsp_data, 0);
        chk("rst_rsp_err", bus.rsp_err, 0);
        chk("rst_mem_req", bus.mem_req, 0);
        chk("rst_mem_we", bus.mem_we, 0);
        chk("rst_mem_addr", bus.mem_addr, 0);
        chk("rst_mem_wdata", bus.mem_wdata, 0);
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("rsp_valid_idle_after_reset", bus.rsp_valid, 0);

        rdy_mode = 2;
        issue(2'd1, 16'h0, 16'h0, 12'd3);          // CAR 3 -> 0x0002 via addr 4
        issue(2'd2, 16'h0, 16'h0, 12'd3);          // CDR 3 -> 0x0001
        issue(2'd0, 16'h1234, 16'h5678, 12'd0);    // CONS -> 5
        issue(2'd1, 16'h0, 16'h0, 12'd5);          // CAR 5 -> 0x1234
        issue(2'd1, 16'h0, 16'h0, 12'd0);          // CAR NIL
        issue(2'd2, 16'h0, 16'h0, 12'd255);        // out of range
        issue(2'd3, 16'h0, 16'h0, 12'd3);          // reserved op
        drain("drain_directed");

        // stalled response
        rdy_mode = 1;
        issue(2'd2, 16'h0, 16'h0, 12'd5);
        t0 = 0;
        while (!bus.rsp_valid && t0 < 20) begin @(negedge clk); t0++; end
        if (!bus.rsp_valid) fail_now("stall_rsp_valid");
        repeat (4) @(negedge clk);
        rdy_mode = 2;
        drain("drain_stall");

        // reset during WR_CAR leaves an orphan CDR word
        keep = mdl_next;
        issue(2'd0, 16'hbeef, 16'hcafe, 12'd0);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("midrst_cmd_ready", bus.cmd_ready, 1);
        chk("midrst_rsp_valid", bus.rsp_valid, 0);
        chk("midrst_mem_we", bus.mem_we, 0);
        chk("midrst_mem_wdata", bus.mem_wdata, 0);
        chk("midrst_rsp_data", bus.rsp_data, 0);
        sb.delete(); exp_wr.delete(); exp_rd.delete();
        void'(cons_ptrs.pop_back());
        mdl_next = keep + 1;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        issue(2'd0, 16'h0a0a, 16'h0b0b, 12'd0);
        drain("drain_after_reset");

        // random traffic; enough CONS to run the allocator past the end of the heap
        rdy_mode = 0;
        for (int n = 0; n < 400; n++) begin
            r = $urandom_range(0, 9);
            case ($urandom_range(0, 4))
                0:       rp = 12'd0;
                1:       rp = 12'($urandom_range(0, 300));
                2:       rp = ($urandom_range(0, 1) != 0) ? 12'd254 : 12'd255;
                default: rp = (cons_ptrs.size() != 0) ?
                              cons_ptrs[$urandom_range(0, cons_ptrs.size() - 1)] : 12'd3;
            endcase
            if (r < 4)      issue(2'd0, 16'($urandom), 16'($urandom), 12'($urandom));
            else if (r < 6) issue(2'd1, 16'($urandom), 16'($urandom), rp);
            else if (r < 9) issue(2'd2, 16'($urandom), 16'($urandom), rp);
            else            issue(2'd3, 16'($urandom), 16'($urandom), rp);
            repeat ($urandom_range(0, 2)) @(posedge clk);
        end
        rdy_mode = 2;
        drain("drain_random");
        repeat (3) @(negedge clk);
        chk("writes_left", exp_wr.size(), 0);
        chk("reads_left", exp_rd.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
